// File: rtl/insn_fetch_ctrl.sv
// insn_fetch_ctrl
//   Assembles one 32-bit big-endian instruction from a byte-wide instruction
//   memory with a fixed 1-cycle read latency, then holds it on a valid/ready
//   handshake until consumed.
//
//   Sequence per fetch: ISSUE x4 (one byte request per cycle, cnt 0..3),
//   LAST (final byte arrives), VALID (instruction offered to the consumer).
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   mem_rd_en, mem_addr byte read request to instruction memory
//   mem_rdata           byte returned one cycle after the request
//   redirect/_pc        flush and restart at redirect_pc (word aligned)
//   insn_valid/_ready   instruction handshake
//   insn, insn_pc       assembled instruction and its address
module insn_fetch_ctrl #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_rd_en,
  output logic [63:0] mem_addr,
  input  logic [7:0]  mem_rdata,
  input  logic        redirect,
  input  logic [63:0] redirect_pc,
  output logic        insn_valid,
  input  logic        insn_ready,
  output logic [31:0] insn,
  output logic [63:0] insn_pc
);

  typedef enum logic [1:0] {ISSUE, LAST, VALID} state_t;

  state_t      state, state_nxt;
  logic [1:0]  cnt, cnt_nxt;
  logic [63:0] pc, pc_nxt;
  logic [31:0] insn_q;

  // cnt parks at 3 after the last request, so the address simply holds
  // pc+3 through LAST and VALID without extra muxing.
  assign mem_addr = pc + {62'd0, cnt};
  assign insn     = insn_q;
  assign insn_pc  = pc;

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    pc_nxt     = pc;
    mem_rd_en  = 1'b0;
    insn_valid = 1'b0;
    case (state)
      ISSUE: begin
        mem_rd_en = 1'b1;
        if (cnt == 2'd3) state_nxt = LAST;
        else             cnt_nxt   = cnt + 2'd1;
      end
      LAST:  state_nxt = VALID;
      VALID: begin
        insn_valid = 1'b1;
        if (insn_ready) begin
          state_nxt = ISSUE;
          cnt_nxt   = 2'd0;
          pc_nxt    = pc + 64'd4;
        end
      end
      default: state_nxt = ISSUE;
    endcase
    // Redirect overrides any handshake in the same cycle; the offered
    // instruction is treated as consumed and pc+4 is never fetched.
    if (redirect) begin
      state_nxt = ISSUE;
      cnt_nxt   = 2'd0;
      pc_nxt    = {redirect_pc[63:2], 2'b00};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ISSUE;
      cnt    <= 2'd0;
      pc     <= RESET_PC;
      insn_q <= 32'h0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      pc    <= pc_nxt;
      // mem_rdata carries the byte requested last cycle: in ISSUE with
      // cnt=n that is byte n-1; in LAST it is byte 3. A redirect may leave
      // stale bytes here, but every byte is rewritten before VALID.
      if (state == ISSUE) begin
        case (cnt)
          2'd1:    insn_q[31:24] <= mem_rdata;
          2'd2:    insn_q[23:16] <= mem_rdata;
          2'd3:    insn_q[15:8]  <= mem_rdata;
          default: ;
        endcase
      end else if (state == LAST) begin
        insn_q[7:0] <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_insn_fetch_ctrl.sv
module tb_insn_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_rd_en, mem_rd_en2;
  logic [63:0] mem_addr, mem_addr2;
  logic [7:0]  mem_rdata = 8'h0, mem_rdata2 = 8'h0;
  logic        redirect, redirect2;
  logic [63:0] redirect_pc, redirect_pc2;
  logic        insn_valid, insn_valid2;
  logic        insn_ready, insn_ready2;
  logic [31:0] insn, insn2;
  logic [63:0] insn_pc, insn_pc2;

  int tests = 0;
  int fails = 0;

  typedef struct { logic [31:0] insn; logic [63:0] pc; } exp_t;
  exp_t sb[$];
  logic [7:0] mem [logic [63:0]];

  always #5 clk = ~clk;

  insn_fetch_ctrl #(.RESET_PC(64'h0)) dut (
    .clk(clk), .reset(reset), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .redirect(redirect), .redirect_pc(redirect_pc),
    .insn_valid(insn_valid), .insn_ready(insn_ready), .insn(insn), .insn_pc(insn_pc)
  );

  insn_fetch_ctrl #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) dut2 (
    .clk(clk), .reset(reset), .mem_rd_en(mem_rd_en2), .mem_addr(mem_addr2),
    .mem_rdata(mem_rdata2), .redirect(redirect2), .redirect_pc(redirect_pc2),
    .insn_valid(insn_valid2), .insn_ready(insn_ready2), .insn(insn2), .insn_pc(insn_pc2)
  );

  function automatic logic [7:0] mb(input logic [63:0] a);
    if (mem.exists(a)) return mem[a];
    return a[7:0] ^ a[15:8] ^ 8'hC3 ^ a[63:56];
  endfunction

  function automatic logic [31:0] model(input logic [63:0] p);
    return {mb(p), mb(p + 64'd1), mb(p + 64'd2), mb(p + 64'd3)};
  endfunction

  // 1-cycle latency byte memory for each instance
  always @(posedge clk) begin
    if (mem_rd_en)  mem_rdata  <= mb(mem_addr);
    if (mem_rd_en2) mem_rdata2 <= mb(mem_addr2);
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [63:0] p);
    exp_t e;
    e.insn = model(p);
    e.pc   = p;
    sb.push_back(e);
  endtask

  // Pops the oldest expectation and compares it with what the DUT offers.
  task automatic pop_cmp(input string name);
    exp_t e;
    tests++;
    if (sb.size() == 0) begin
      fails++; $display("FAIL %s: scoreboard empty at insn=%h pc=%h", name, insn, insn_pc);
    end else begin
      e = sb.pop_front();
      if (insn !== e.insn || insn_pc !== e.pc) begin
        fails++;
        $display("FAIL %s: insn=%h pc=%h expected insn=%h pc=%h", name, insn, insn_pc, e.insn, e.pc);
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; redirect = 1'b0; redirect_pc = 64'h0; insn_ready = 1'b0;
    sb.delete();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; redirect = 1'b0; insn_ready = 1'b0;
    step(); step();
    tests++;
    if (insn_valid !== 1'b0 || insn !== 32'h0 || insn_pc !== 64'h0) begin
      fails++; $display("FAIL reset_state: valid=%b insn=%h pc=%h expected 0 0 0", insn_valid, insn, insn_pc);
    end
    reset = 1'b0;
    tests++;
    if (mem_rd_en !== 1'b1 || mem_addr !== 64'h0) begin
      fails++; $display("FAIL reset_first_req: rd_en=%b addr=%h expected 1 0", mem_rd_en, mem_addr);
    end
  endtask

  task automatic test_basic();
    int bad = 0;
    do_reset();
    insn_ready = 1'b1;
    push(64'h0);
    for (int c = 0; c < 4; c++) begin
      if (mem_rd_en !== 1'b1 || mem_addr !== 64'(c) || insn_valid !== 1'b0) bad++;
      step();
    end
    tests++;
    if (bad != 0) begin
      fails++; $display("FAIL basic_issue: %0d bad issue cycles, expected 0", bad);
    end
    tests++;
    if (mem_rd_en !== 1'b0 || insn_valid !== 1'b0) begin
      fails++; $display("FAIL basic_last: rd_en=%b valid=%b expected 0 0", mem_rd_en, insn_valid);
    end
    step();
    tests++;
    if (insn_valid !== 1'b1 || insn !== 32'h00500093) begin
      fails++; $display("FAIL basic_valid: valid=%b insn=%h expected 1 00500093", insn_valid, insn);
    end
    pop_cmp("basic_sb");
    step();
    tests++;
    if (insn_valid !== 1'b0 || mem_rd_en !== 1'b1 || mem_addr !== 64'h4) begin
      fails++; $display("FAIL basic_next: valid=%b rd_en=%b addr=%h expected 0 1 4", insn_valid, mem_rd_en, mem_addr);
    end
  endtask

  task automatic test_stall();
    logic [31:0] hi;
    logic [63:0] hp;
    int bad = 0;
    do_reset();
    push(64'h0);
    repeat (5) step();
    tests++;
    if (insn_valid !== 1'b1) begin
      fails++; $display("FAIL stall_valid: valid=%b expected 1", insn_valid);
    end
    pop_cmp("stall_sb");
    hi = model(64'h0); hp = 64'h0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (insn_valid !== 1'b1 || insn !== hi || insn_pc !== hp || mem_rd_en !== 1'b0) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++; $display("FAIL stall_hold: %0d unstable cycles, expected 0", bad);
    end
    insn_ready = 1'b1;
    step();
    tests++;
    if (insn_valid !== 1'b0 || mem_rd_en !== 1'b1 || mem_addr !== 64'h4) begin
      fails++; $display("FAIL stall_release: valid=%b rd_en=%b addr=%h expected 0 1 4", insn_valid, mem_rd_en, mem_addr);
    end
  endtask

  task automatic test_redirect();
    do_reset();
    insn_ready = 1'b1;
    step(); step();
    redirect = 1'b1; redirect_pc = 64'h103;
    step();
    redirect = 1'b0;
    tests++;
    if (mem_rd_en !== 1'b1 || mem_addr !== 64'h100) begin
      fails++; $display("FAIL redirect_req: rd_en=%b addr=%h expected 1 100", mem_rd_en, mem_addr);
    end
    push(64'h100);
    repeat (4) step();
    tests++;
    if (insn_valid !== 1'b0) begin
      fails++; $display("FAIL redirect_early: valid=%b expected 0", insn_valid);
    end
    step();
    tests++;
    if (insn_valid !== 1'b1) begin
      fails++; $display("FAIL redirect_valid: valid=%b expected 1", insn_valid);
    end
    pop_cmp("redirect_sb");
  endtask

  task automatic test_redirect_handshake();
    logic saw_c = 1'b0;
    do_reset();
    redirect = 1'b1; redirect_pc = 64'h8;
    step();
    redirect = 1'b0;
    push(64'h8);
    repeat (5) step();
    tests++;
    if (insn_valid !== 1'b1 || insn_pc !== 64'h8) begin
      fails++; $display("FAIL rh_valid: valid=%b pc=%h expected 1 8", insn_valid, insn_pc);
    end
    pop_cmp("rh_sb8");
    insn_ready = 1'b1; redirect = 1'b1; redirect_pc = 64'h40;
    step();
    redirect = 1'b0;
    tests++;
    if (mem_rd_en !== 1'b1 || mem_addr !== 64'h40 || insn_valid !== 1'b0) begin
      fails++; $display("FAIL rh_target: rd_en=%b addr=%h valid=%b expected 1 40 0", mem_rd_en, mem_addr, insn_valid);
    end
    push(64'h40);
    for (int i = 0; i < 5; i++) begin
      if (mem_rd_en && mem_addr == 64'hC) saw_c = 1'b1;
      step();
    end
    tests++;
    if (saw_c !== 1'b0) begin
      fails++; $display("FAIL rh_no_c: saw addr C=%b expected 0", saw_c);
    end
    pop_cmp("rh_sb40");
  endtask

  task automatic test_back_to_back();
    int bad = 0;
    do_reset();
    insn_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      push(64'(4 * k));
      repeat (5) step();
      if (insn_valid !== 1'b1) bad++;
      pop_cmp("b2b_sb");
      step();
      if (insn_valid !== 1'b0 || mem_addr !== 64'(4 * k + 4)) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++; $display("FAIL b2b_timing: %0d bad cycles, expected 0", bad);
    end
  endtask

  task automatic test_wrap();
    int bad = 0;
    do_reset();
    redirect2 = 1'b0; insn_ready2 = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (mem_rd_en2 !== 1'b1 || mem_addr2 !== 64'hFFFF_FFFF_FFFF_FFFC + 64'(c)) bad++;
      step();
    end
    tests++;
    if (bad != 0) begin
      fails++; $display("FAIL wrap_issue: %0d bad addresses, expected 0", bad);
    end
    step();
    tests++;
    if (insn_valid2 !== 1'b1 || insn_pc2 !== 64'hFFFF_FFFF_FFFF_FFFC || insn2 !== model(64'hFFFF_FFFF_FFFF_FFFC)) begin
      fails++; $display("FAIL wrap_valid: valid=%b pc=%h insn=%h expected 1 fffffffffffffffc %h",
                        insn_valid2, insn_pc2, insn2, model(64'hFFFF_FFFF_FFFF_FFFC));
    end
    step();
    tests++;
    if (mem_rd_en2 !== 1'b1 || mem_addr2 !== 64'h0) begin
      fails++; $display("FAIL wrap_zero: rd_en=%b addr=%h expected 1 0", mem_rd_en2, mem_addr2);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    insn_ready = 1'b1;
    repeat (4) step();
    reset = 1'b1;
    step();
    tests++;
    if (insn_valid !== 1'b0 || insn !== 32'h0) begin
      fails++; $display("FAIL rmid_clear: valid=%b insn=%h expected 0 0", insn_valid, insn);
    end
    reset = 1'b0;
    tests++;
    if (mem_rd_en !== 1'b1 || mem_addr !== 64'h0) begin
      fails++; $display("FAIL rmid_restart: rd_en=%b addr=%h expected 1 0", mem_rd_en, mem_addr);
    end
    push(64'h0);
    repeat (5) step();
    tests++;
    if (insn_valid !== 1'b1) begin
      fails++; $display("FAIL rmid_valid: valid=%b expected 1", insn_valid);
    end
    pop_cmp("rmid_sb");
  endtask

  initial begin
    mem[64'h0] = 8'h00; mem[64'h1] = 8'h50; mem[64'h2] = 8'h00; mem[64'h3] = 8'h93;
    reset = 1'b1; redirect = 1'b0; redirect_pc = 64'h0; insn_ready = 1'b0;
    redirect2 = 1'b0; redirect_pc2 = 64'h0; insn_ready2 = 1'b1;
    #1;
    test_reset();
    test_basic();
    test_stall();
    test_redirect();
    test_redirect_handshake();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
